// File: rtl/debounce_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi_if
// Description : Bundles the raw inputs and debounced outputs of debounce_multi.
// Revision    : 1.0 - initial release
// ============================================================================
interface debounce_multi_if #(
    parameter int N = 4
);
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] hold;
    logic [N-1:0] hold_pulse;

    // master drives the pins (board side); slave is the debouncer itself
    modport master (
        output btn_in,
        input  btn_db,
        input  rise,
        input  fall,
        input  hold,
        input  hold_pulse
    );

    modport slave (
        input  btn_in,
        output btn_db,
        output rise,
        output fall,
        output hold,
        output hold_pulse
    );
endinterface
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N-channel debouncer with press/release pulses and hold detect.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int N           = 4,
    parameter int DELAY       = 100000,
    parameter int HOLD_CYCLES = 0,
    parameter int ACTIVE_LOW  = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    debounce_multi_if.slave  bus
);
    localparam int             CW         = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam logic [CW-1:0]  c_cnt_last = CW'(DELAY - 1);

    logic [N-1:0] w_raw;
    logic [N-1:0] w_db;
    logic [N-1:0] w_rise;
    logic [N-1:0] w_fall;
    logic [N-1:0] w_hold;
    logic [N-1:0] w_hold_pulse;

    assign w_raw = (ACTIVE_LOW != 0) ? ~bus.btn_in : bus.btn_in;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          s1_q, s1_d;
        logic          s2_q, s2_d;
        logic          db_q, db_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic [CW-1:0] cnt_q, cnt_d;

        // The counter measures consecutive disagreement between the
        // synchronised input and the accepted level; any agreement restarts it.
        always_comb begin
            s1_d  = w_raw[i];
            s2_d  = s1_q;
            db_d  = db_q;
            cnt_d = '0;
            if (s2_q != db_q) begin
                if (cnt_q == c_cnt_last) begin
                    db_d  = s2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            rise_d = db_d & ~db_q;
            fall_d = ~db_d & db_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                db_q   <= 1'b0;
                cnt_q  <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                s1_q   <= s1_d;
                s2_q   <= s2_d;
                db_q   <= db_d;
                cnt_q  <= cnt_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign w_db[i]   = db_q;
        assign w_rise[i] = rise_q;
        assign w_fall[i] = fall_q;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int             HW         = $clog2(HOLD_CYCLES + 1);
            localparam logic [HW-1:0]  c_hold_max = HW'(HOLD_CYCLES);

            logic [HW-1:0] hcnt_q, hcnt_d;
            logic          hold_q, hold_d;
            logic          hpulse_q, hpulse_d;
            logic          w_hold_set;

            // Gating with db_d makes hold drop on the very edge btn_db falls.
            always_comb begin
                hcnt_d = '0;
                if (db_q) begin
                    hcnt_d = (hcnt_q == c_hold_max) ? hcnt_q : hcnt_q + HW'(1);
                end
                w_hold_set = db_q && (hcnt_q != c_hold_max) && (hcnt_d == c_hold_max);
                hold_d     = db_d & (hold_q | w_hold_set);
                hpulse_d   = db_d & w_hold_set;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hcnt_q   <= '0;
                    hold_q   <= 1'b0;
                    hpulse_q <= 1'b0;
                end else begin
                    hcnt_q   <= hcnt_d;
                    hold_q   <= hold_d;
                    hpulse_q <= hpulse_d;
                end
            end

            assign w_hold[i]       = hold_q;
            assign w_hold_pulse[i] = hpulse_q;
        end else begin : g_no_hold
            assign w_hold[i]       = 1'b0;
            assign w_hold_pulse[i] = 1'b0;
        end
    end

    assign bus.btn_db     = w_db;
    assign bus.rise       = w_rise;
    assign bus.fall       = w_fall;
    assign bus.hold       = w_hold;
    assign bus.hold_pulse = w_hold_pulse;

endmodule
`default_nettype wire
